// File: rtl/soc_system_dcc_cmd_out.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_dcc_cmd_out
// Purpose  : Memory-mapped command-output port. The CPU pushes 32-bit words
//            through a 4-word register window into a DEPTH-deep FIFO which
//            drains to fabric over a valid/ready stream. Sticky events
//            (drained, overflow, sent) raise a maskable level interrupt.
// Ports    : clk, reset_n (async, active-low)
//            address/chipselect/write_n/writedata/readdata : register slave
//            irq                                            : level interrupt
//            out_data/out_valid/out_ready                   : fabric stream
// Register map (word addresses):
//            0 W push word            0 R head word (out_data)
//            1 W bit0=1 flush         1 R {14'b0, empty, full, 16'(count)}
//            2 RW irq_mask[2:0]       3 R event[2:0], W1C
// Revision : 1.0  initial release
// ============================================================================
module soc_system_dcc_cmd_out #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_one   = (AW+1)'(1);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [2:0]    r_irq_mask;
  logic [2:0]    r_event;

  logic          w_wr;
  logic          w_push;
  logic          w_accept;
  logic          w_pop;
  logic          w_flush;
  logic          w_empty;
  logic          w_full;
  logic [2:0]    w_event_set;
  logic [2:0]    w_event_clr;
  logic [AW:0]   w_count_nxt;

  assign w_wr    = chipselect & ~write_n;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);

  // Acceptance looks only at the registered count, so a push while full is
  // dropped even when a pop frees a slot in the same cycle.
  assign w_push   = w_wr && (address == 2'd0);
  assign w_accept = w_push && !w_full;
  assign w_pop    = out_valid && out_ready;
  assign w_flush  = w_wr && (address == 2'd1) && writedata[0];

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 32'd0 : r_mem[r_rd_ptr];
  assign irq       = |(r_event & r_irq_mask);

  // Drained only counts a genuine 1->0 transition through a pop; a
  // simultaneous push keeps the count at 1 and a flush suppresses it.
  assign w_event_set[0] = w_pop && (r_count == c_one) && !w_accept && !w_flush;
  assign w_event_set[1] = w_push && w_full;
  assign w_event_set[2] = w_pop;
  assign w_event_clr    = (w_wr && (address == 2'd3)) ? writedata[2:0] : 3'b000;

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   w_count_nxt = r_count + c_one;
        2'b01:   w_count_nxt = r_count - c_one;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // FIFO storage carries no reset; only valid entries are ever observed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_irq_mask <= 3'b000;
      r_event    <= 3'b000;
      readdata   <= 32'd0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;

      if (w_wr && (address == 2'd2)) begin
        r_irq_mask <= writedata[2:0];
      end
      // Set dominates a simultaneous write-1-to-clear.
      r_event <= (r_event & ~w_event_clr) | w_event_set;

      case (address)
        2'd0:    readdata <= out_data;
        2'd1:    readdata <= {14'b0, w_empty, w_full, 16'(r_count)};
        2'd2:    readdata <= {29'b0, r_irq_mask};
        default: readdata <= {29'b0, r_event};
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_system_dcc_cmd_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_dcc_cmd_out
// Purpose  : Self-checking bench for soc_system_dcc_cmd_out. A queue-based
//            reference model tracks the expected FIFO contents, events, mask
//            and registered read data; a negedge monitor compares the DUT
//            outputs against it. Directed scenarios add constant checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_soc_system_dcc_cmd_out;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  soc_system_dcc_cmd_out #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  logic [2:0]  m_mask;
  logic [2:0]  m_event;
  logic [31:0] m_rd;
  int          m_sz;
  logic        m_wr, m_pop, m_push, m_acc, m_flush;
  logic [2:0]  m_set, m_clr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_mask  = 3'b000;
      m_event = 3'b000;
      m_rd    = 32'd0;
    end else begin
      m_sz    = mq.size();
      m_wr    = chipselect && !write_n;
      case (address)
        2'd0:    m_rd = (m_sz > 0) ? mq[0] : 32'd0;
        2'd1:    m_rd = ((m_sz == 0) ? 32'h0002_0000 : 32'd0) |
                        ((m_sz == DEPTH) ? 32'h0001_0000 : 32'd0) | 32'(m_sz);
        2'd2:    m_rd = {29'd0, m_mask};
        default: m_rd = {29'd0, m_event};
      endcase
      m_pop   = (m_sz > 0) && out_ready;
      m_push  = m_wr && (address == 2'd0);
      m_acc   = m_push && (m_sz < DEPTH);
      m_flush = m_wr && (address == 2'd1) && writedata[0];
      m_set   = {m_pop, m_push && !m_acc, m_pop && (m_sz == 1) && !m_acc && !m_flush};
      m_clr   = (m_wr && address == 2'd3) ? writedata[2:0] : 3'b000;
      m_event = (m_event & ~m_clr) | m_set;
      if (m_wr && address == 2'd2) m_mask = writedata[2:0];
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back(writedata);
      if (m_flush) mq.delete();
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("irq", {31'd0, irq}, {31'd0, |(m_event & m_mask)});
      chk("readdata", readdata, m_rd);
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
      else                chk("out_data_empty", out_data, 32'd0);
      if (out_valid && out_ready) n_xfer++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic cs, input logic wn, input logic [1:0] a,
                     input logic [31:0] wd, input logic rdy);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    out_ready  = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] w, input logic rdy);
    cyc(1'b1, 1'b0, 2'd0, w, rdy);
  endtask

  task automatic wreg(input logic [1:0] a, input logic [31:0] w, input logic rdy);
    cyc(1'b1, 1'b0, a, w, rdy);
  endtask

  task automatic rreg(input logic [1:0] a, input logic rdy);
    cyc(1'b1, 1'b1, a, 32'd0, rdy);
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 2'd0, 32'd0, rdy);
  endtask

  logic [1:0]  r_a;
  logic [31:0] r_w;

  initial begin
    // 1. reset state
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    rreg(2'd1, 1'b0);
    chk("t1_status", readdata, 32'h0002_0000);
    chk("t1_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_irq", {31'd0, irq}, 32'd0);

    // 2. single push, show-ahead after one edge
    push(32'hA5A5_0001, 1'b0);
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_data", out_data, 32'hA5A5_0001);
    rreg(2'd1, 1'b0);
    chk("t2_status", readdata, 32'h0000_0001);

    // 3. overflow with 9 pushes
    wreg(2'd1, 32'h1, 1'b0);
    for (int i = 0; i < 9; i++) push(32'hB000_0000 + 32'(i), 1'b0);
    rreg(2'd1, 1'b0);
    chk("t3_status", readdata, 32'h0001_0008);
    rreg(2'd3, 1'b0);
    chk("t3_event", readdata, 32'h0000_0002);
    n_xfer = 0;
    idle(1'b1, 10);
    chk("t3_xfers", 32'(n_xfer), 32'd8);

    // 4. drained + sent events with irq on drained
    wreg(2'd3, 32'h7, 1'b0);
    wreg(2'd2, 32'h1, 1'b0);
    push(32'hC000_0001, 1'b1);
    push(32'hC000_0002, 1'b1);
    idle(1'b1, 1);
    rreg(2'd3, 1'b1);
    chk("t4_event", readdata, 32'h0000_0005);
    chk("t4_irq_on", {31'd0, irq}, 32'd1);
    wreg(2'd3, 32'h1, 1'b0);
    chk("t4_irq_off", {31'd0, irq}, 32'd0);
    rreg(2'd3, 1'b0);
    chk("t4_event_clr", readdata, 32'h0000_0004);

    // 5. push while full with pop: dropped; then push+pop at 7
    wreg(2'd3, 32'h7, 1'b0);
    for (int i = 0; i < DEPTH; i++) push(32'hD000_0000 + 32'(i), 1'b0);
    push(32'hDEAD_0000, 1'b1);
    push(32'hD000_0100, 1'b1);
    rreg(2'd1, 1'b0);
    chk("t5_status", readdata, 32'h0000_0007);
    rreg(2'd3, 1'b0);
    chk("t5_ovf", readdata & 32'h2, 32'h2);
    idle(1'b1, 10);

    // 6. flush, then async reset mid-stream
    wreg(2'd3, 32'h7, 1'b0);
    for (int i = 0; i < 5; i++) push(32'hE000_0000 + 32'(i), 1'b0);
    wreg(2'd1, 32'h1, 1'b0);
    chk("t6_flush_valid", {31'd0, out_valid}, 32'd0);
    rreg(2'd3, 1'b0);
    chk("t6_no_drain", readdata & 32'h1, 32'h0);
    wreg(2'd2, 32'h4, 1'b0);
    for (int i = 0; i < 3; i++) push(32'hF000_0000 + 32'(i), 1'b0);
    idle(1'b1, 1);
    idle(1'b0, 1);
    chk("t6_irq_pre", {31'd0, irq}, 32'd1);
    rreg(2'd0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_irq", {31'd0, irq}, 32'd0);
    chk("t6_rst_rd", readdata, 32'd0);
    idle(1'b0, 2);
    reset_n = 1'b1;
    idle(1'b0, 1);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: r_a = 2'd0;
        5:             r_a = 2'd1;
        6, 7:          r_a = 2'd2;
        default:       r_a = 2'd3;
      endcase
      r_w = $urandom;
      if (r_a == 2'd1) r_w[0] = ($urandom_range(0, 7) == 0);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_a, r_w,
          1'($urandom_range(0, 2) == 0));
    end
    idle(1'b1, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
